// File: rtl/ovl_incr_stim_gen_if.sv
// rtl/ovl_incr_stim_gen_if.sv - run request, configuration and generated-value bundle for ovl_incr_stim_gen
interface ovl_incr_stim_gen_if #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 4
);
  logic              start;
  logic [WIDTH-1:0]  init_val;
  logic [WIDTH-1:0]  step;
  logic [CNT_W-1:0]  num_updates;
  logic [HOLD_W-1:0] hold_cycles;
  logic [CNT_W-1:0]  err_at;
  logic [WIDTH-1:0]  test_expr;
  logic              busy;
  logic              done;
  logic              expect_fire;
  logic [CNT_W-1:0]  upd_idx;

  modport master (
    output start, init_val, step, num_updates, hold_cycles, err_at,
    input  test_expr, busy, done, expect_fire, upd_idx
  );

  modport slave (
    input  start, init_val, step, num_updates, hold_cycles, err_at,
    output test_expr, busy, done, expect_fire, upd_idx
  );
endinterface

// File: rtl/ovl_incr_stim_gen.sv
// rtl/ovl_incr_stim_gen.sv - incrementing stimulus source for an ovl_increment checker, with one optional bad step
module ovl_incr_stim_gen #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  ovl_incr_stim_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  value_q, value_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              fire_q, fire_n;
  logic [CNT_W-1:0]  upd_q, upd_n;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_n;
  logic [WIDTH-1:0]  step_q, step_n;
  logic [CNT_W-1:0]  num_q, num_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [CNT_W-1:0]  err_q, err_n;

  logic [CNT_W-1:0]  upd_inc;
  logic              inject;

  // upd_inc never wraps to 0 inside a run, so err_at == 0 can never match
  assign upd_inc = upd_q + CNT_W'(1);
  assign inject  = (upd_inc == err_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      value_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fire_q     <= 1'b0;
      upd_q      <= '0;
      hold_cnt_q <= '0;
      step_q     <= '0;
      num_q      <= '0;
      hold_q     <= '0;
      err_q      <= '0;
    end else begin
      state      <= state_n;
      value_q    <= value_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      fire_q     <= fire_n;
      upd_q      <= upd_n;
      hold_cnt_q <= hold_cnt_n;
      step_q     <= step_n;
      num_q      <= num_n;
      hold_q     <= hold_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    value_n    = value_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    fire_n     = 1'b0;
    upd_n      = upd_q;
    hold_cnt_n = hold_cnt_q;
    step_n     = step_q;
    num_n      = num_q;
    hold_n     = hold_q;
    err_n      = err_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          step_n     = bus.step;
          num_n      = bus.num_updates;
          hold_n     = bus.hold_cycles;
          err_n      = bus.err_at;
          value_n    = bus.init_val;
          busy_n     = 1'b1;
          upd_n      = '0;
          hold_cnt_n = bus.hold_cycles;
          state_n    = (bus.num_updates == '0) ? DONE : HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_n = hold_cnt_q - HOLD_W'(1);
        end else begin
          value_n = value_q + step_q + WIDTH'(inject);
          fire_n  = inject;
          upd_n   = upd_inc;
          if (upd_inc == num_q) begin
            state_n = DONE;
          end else begin
            hold_cnt_n = hold_q;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.test_expr   = value_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.expect_fire = fire_q;
  assign bus.upd_idx     = upd_q;

endmodule

// File: tb/tb_ovl_incr_stim_gen.sv
// tb/tb_ovl_incr_stim_gen.sv - directed self-checking bench for ovl_incr_stim_gen
module tb_ovl_incr_stim_gen;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ovl_incr_stim_gen_if #(.WIDTH(4), .CNT_W(8), .HOLD_W(4)) bus ();

  ovl_incr_stim_gen #(.WIDTH(4), .CNT_W(8), .HOLD_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Start pulse covers edge E0; returns at the following negedge so outputs reflect E0
  task automatic do_start(input int iv, input int st, input int nu, input int hc, input int ea);
    @(negedge clock);
    bus.init_val    = 4'(iv);
    bus.step        = 4'(st);
    bus.num_updates = 8'(nu);
    bus.hold_cycles = 4'(hc);
    bus.err_at      = 8'(ea);
    bus.start       = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (bus.test_expr !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.expect_fire !== 1'b0 || bus.upd_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got val=%0d busy=%0b done=%0b fire=%0b idx=%0d exp all 0",
               bus.test_expr, bus.busy, bus.done, bus.expect_fire, bus.upd_idx);
    end
  endtask

  task automatic test_basic();
    int ev[5], eb[5], ed[5];
    ev = '{0, 2, 4, 6, 6};
    eb = '{1, 1, 1, 1, 0};
    ed = '{0, 0, 0, 0, 1};
    do_start(0, 2, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.busy !== 1'(eb[i]) ||
          bus.done !== 1'(ed[i]) || bus.expect_fire !== 1'b0) begin
        errors++;
        $display("FAIL basic E%0d got val=%0d busy=%0b done=%0b fire=%0b exp val=%0d busy=%0d done=%0d fire=0",
                 i, bus.test_expr, bus.busy, bus.done, bus.expect_fire, ev[i], eb[i], ed[i]);
      end
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.test_expr !== 4'd6) begin
      errors++;
      $display("FAIL basic_after_done got done=%0b val=%0d exp done=0 val=6", bus.done, bus.test_expr);
    end
  endtask

  task automatic test_hold();
    int ev[8], ed[8];
    ev = '{0, 0, 0, 1, 1, 1, 2, 2};
    ed = '{0, 0, 0, 0, 0, 0, 0, 1};
    do_start(0, 1, 2, 2, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.done !== 1'(ed[i])) begin
        errors++;
        $display("FAIL hold E%0d got val=%0d done=%0b exp val=%0d done=%0d",
                 i, bus.test_expr, bus.done, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_error_inject();
    int ev[5], ef[5], ed[5];
    int fires;
    ev = '{0, 2, 5, 7, 7};
    ef = '{0, 0, 1, 0, 0};
    ed = '{0, 0, 0, 0, 1};
    fires = 0;
    do_start(0, 2, 3, 0, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      if (bus.expect_fire === 1'b1) fires++;
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.expect_fire !== 1'(ef[i]) || bus.done !== 1'(ed[i])) begin
        errors++;
        $display("FAIL err_inject E%0d got val=%0d fire=%0b done=%0b exp val=%0d fire=%0d done=%0d",
                 i, bus.test_expr, bus.expect_fire, bus.done, ev[i], ef[i], ed[i]);
      end
    end
    checks++;
    if (fires != 1) begin
      errors++;
      $display("FAIL err_inject_count got %0d fire cycles exp 1", fires);
    end
  endtask

  task automatic test_error_last_and_beyond();
    int ev[4], ef[4];
    // err_at equals num_updates: last value corrupted, then DONE
    ev = '{0, 1, 3, 3};
    ef = '{0, 0, 1, 0};
    do_start(0, 1, 2, 0, 2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.expect_fire !== 1'(ef[i]) || bus.done !== (i == 3)) begin
        errors++;
        $display("FAIL err_last E%0d got val=%0d fire=%0b done=%0b exp val=%0d fire=%0d done=%0d",
                 i, bus.test_expr, bus.expect_fire, bus.done, ev[i], ef[i], (i == 3));
      end
    end
    // err_at beyond num_updates: no injection
    ev = '{0, 1, 2, 2};
    do_start(0, 1, 2, 0, 5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.expect_fire !== 1'b0) begin
        errors++;
        $display("FAIL err_beyond E%0d got val=%0d fire=%0b exp val=%0d fire=0",
                 i, bus.test_expr, bus.expect_fire, ev[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int ev[5];
    ev = '{14, 15, 0, 1, 1};
    do_start(14, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.expect_fire !== 1'b0 || bus.done !== (i == 4)) begin
        errors++;
        $display("FAIL wrap E%0d got val=%0d fire=%0b done=%0b exp val=%0d fire=0 done=%0d",
                 i, bus.test_expr, bus.expect_fire, bus.done, ev[i], (i == 4));
      end
    end
  endtask

  task automatic test_zero_updates();
    do_start(5, 1, 0, 0, 0);
    checks++;
    if (bus.test_expr !== 4'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL zero_E0 got val=%0d busy=%0b done=%0b exp val=5 busy=1 done=0",
               bus.test_expr, bus.busy, bus.done);
    end
    // start held across the DONE edge (ignored) and the edge after it (accepted)
    bus.init_val = 4'd7;
    bus.start    = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.test_expr !== 4'd5) begin
      errors++;
      $display("FAIL zero_E1 got done=%0b busy=%0b val=%0d exp done=1 busy=0 val=5",
               bus.done, bus.busy, bus.test_expr);
    end
    @(negedge clock);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.test_expr !== 4'd7 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_done got busy=%0b val=%0d done=%0b exp busy=1 val=7 done=0",
               bus.busy, bus.test_expr, bus.done);
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got %0b exp 1", bus.done);
    end
  endtask

  task automatic test_ignored_start();
    int ev[8], ei[8];
    ev = '{0, 0, 1, 1, 2, 2, 3, 3};
    ei = '{0, 0, 1, 1, 2, 2, 3, 3};
    do_start(0, 1, 3, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 1) begin
        bus.init_val    = 4'd9;
        bus.step        = 4'd5;
        bus.num_updates = 8'd1;
        bus.start       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      checks++;
      if (bus.test_expr !== 4'(ev[i]) || bus.upd_idx !== 8'(ei[i]) || bus.done !== (i == 7)) begin
        errors++;
        $display("FAIL ignored_start E%0d got val=%0d idx=%0d done=%0b exp val=%0d idx=%0d done=%0d",
                 i, bus.test_expr, bus.upd_idx, bus.done, ev[i], ei[i], (i == 7));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int dones;
    do_start(0, 1, 3, 3, 0);
    n = 0;
    while (n < 50 && bus.upd_idx !== 8'd1) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.upd_idx !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_wait got idx=%0d exp 1 within 50 cycles", bus.upd_idx);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.test_expr !== 4'd0 || bus.busy !== 1'b0 || bus.upd_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_async got val=%0d busy=%0b idx=%0d exp 0 0 0",
               bus.test_expr, bus.busy, bus.upd_idx);
    end
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d cycles with done/busy exp 0", dones);
    end
    do_start(3, 1, 1, 0, 0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.test_expr !== 4'd4 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL reset_rerun got val=%0d done=%0b exp val=4 done=1", bus.test_expr, bus.done);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.init_val    = '0;
    bus.step        = '0;
    bus.num_updates = '0;
    bus.hold_cycles = '0;
    bus.err_at      = '0;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_basic();
    test_hold();
    test_error_inject();
    test_error_last_and_beyond();
    test_wrap();
    test_zero_updates();
    @(negedge clock);
    test_ignored_start();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
